// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared definitions for the MEM pipeline stage: access-size
//             encodings, FSM state type, and lane helper functions.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Access-size encodings carried on mem_size; 2'b11 behaves as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Memory-access sequencer states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{~uns & b[7]}}, b};
            SZ_HALF: res = {{16{~uns & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Byte-enable mask for a store of the given size at the given offset.
    function automatic logic [3:0] lane_enable(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
//  Module   : data_ram
//  Purpose  : Single-port DEPTH x 32 data memory with per-byte write enables
//             and a registered, read-first read port. Updates on the falling
//             clock edge to line up with the pipeline registers.
//  Revision : 1.0  initial release
// ============================================================================
module data_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-lane write plus registered read of the addressed word.
    always_ff @(negedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    r_mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM stage of the five-stage pipeline. Reads the EX/MEM bundle,
//             performs aligned loads/stores into the internal data RAM with a
//             fixed access latency, stalls upstream while the access is in
//             flight, and drives the MEM/WB register.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU,
    input  logic [31:0] dato_B,
    input  logic [4:0]  rd,
    input  logic [4:0]  rt,
    input  logic        reg_dst,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_we,
    output logic        misalign
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam bit c_MULTI  = (LAT > 1);

    // ------------------------------------------------------------------
    // Op decode and alignment
    // ------------------------------------------------------------------
    logic              w_is_store;
    logic              w_is_load;
    logic              w_mem_op;
    logic              w_misalign;
    logic              w_aligned_op;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_stall;
    logic              w_complete;
    logic [4:0]        w_dest;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_ld_data;
    logic [c_ADDR_W-1:0] w_index;

    mem_state_t        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]       r_wb_data;
    logic [4:0]        r_wb_reg;
    logic              r_wb_we;
    logic              r_misalign;
    logic              r_ld_pend;
    logic [1:0]        r_ld_size;
    logic [1:0]        r_ld_off;
    logic              r_ld_uns;

    // Stores win when both mem_read and mem_write are set.
    assign w_is_store   = mem_write;
    assign w_is_load    = mem_read & ~mem_write;
    assign w_mem_op     = w_is_store | w_is_load;
    assign w_is_half    = (mem_size == SZ_HALF);
    assign w_is_word    = (mem_size == SZ_WORD) || (mem_size == 2'b11);
    assign w_misalign   = w_mem_op & ((w_is_half & ALU[0]) |
                                      (w_is_word & (ALU[1:0] != 2'b00)));
    assign w_aligned_op = w_mem_op & ~w_misalign;
    assign w_dest       = reg_dst ? rd : rt;

    // Upper address bits are dropped so accesses wrap within the RAM.
    assign w_index = ALU[c_ADDR_W+1:2];

    // Stall covers the first LAT-1 edges of an aligned access; reset wins.
    assign w_stall = ~reset &
                     (((r_state == IDLE) & w_aligned_op & c_MULTI) |
                      ((r_state == BUSY) & (r_cnt > c_CNT_W'(1))));

    // An aligned op that is not stalling completes at this edge.
    assign w_complete = ~reset & w_aligned_op & ~w_stall;

    assign w_be    = lane_enable(mem_size, ALU[1:0]);
    assign w_wdata = (mem_size == SZ_BYTE) ? {4{dato_B[7:0]}} :
                     w_is_half             ? {2{dato_B[15:0]}} : dato_B;

    data_ram #(
        .DEPTH (DEPTH)
    ) u_data_ram (
        .clk   (clk),
        .we    (w_complete & w_is_store),
        .be    (w_be),
        .addr  (w_index),
        .wdata (w_wdata),
        .rdata (w_ram_rdata)
    );

    // The RAM read register doubles as the load-data stage of MEM/WB; it is
    // copied into r_wb_data as soon as a bubble would otherwise let it drift.
    assign w_ld_data = load_extend(w_ram_rdata, r_ld_size, r_ld_off, r_ld_uns);

    // Sequencer, latency counter and MEM/WB register update.
    always_ff @(negedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wb_data  <= '0;
            r_wb_reg   <= '0;
            r_wb_we    <= 1'b0;
            r_misalign <= 1'b0;
            r_ld_pend  <= 1'b0;
            r_ld_size  <= SZ_WORD;
            r_ld_off   <= 2'b00;
            r_ld_uns   <= 1'b0;
        end else if (w_stall) begin
            // Bubble: data/reg hold, no write-back, no misalign pulse.
            r_wb_we    <= 1'b0;
            r_misalign <= 1'b0;
            if (r_ld_pend) begin
                r_wb_data <= w_ld_data;
                r_ld_pend <= 1'b0;
            end
            if (r_state == IDLE) begin
                r_state <= BUSY;
                r_cnt   <= c_CNT_W'(LAT - 1);
            end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end else begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wb_reg   <= w_dest;
            r_misalign <= w_misalign;
            r_ld_pend  <= 1'b0;
            if (w_misalign) begin
                r_wb_data <= ALU;
                r_wb_we   <= 1'b0;
            end else if (w_is_store) begin
                r_wb_data <= ALU;
                r_wb_we   <= 1'b0;
            end else if (w_is_load) begin
                r_ld_pend <= 1'b1;
                r_ld_size <= mem_size;
                r_ld_off  <= ALU[1:0];
                r_ld_uns  <= mem_unsigned;
                r_wb_we   <= reg_write;
            end else begin
                r_wb_data <= ALU;
                r_wb_we   <= reg_write;
            end
        end
    end

    assign stall    = w_stall;
    assign wb_data  = r_ld_pend ? w_ld_data : r_wb_data;
    assign wb_reg   = r_wb_reg;
    assign wb_we    = r_wb_we;
    assign misalign = r_misalign;

endmodule
`default_nettype wire
